// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
//   arb_state_t : arbiter FSM state encoding
//   OWNER_M0/M1 : encoding of the last_owner round-robin pointer
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, RELEASE} arb_state_t;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;
endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts wait cycles of a strobed access and flags an expiry
// when no ack/err arrives within TIMEOUT_CYCLES.
//   clk, rst     : clock, asynchronous active-high reset
//   active       : an access is strobed this cycle (pre-timeout-gating)
//   done         : slave answered this cycle (ack or err)
//   adr          : address of the access being watched
//   expire       : combinational, high on the cycle the access times out
//   timeout      : sticky flag, cleared only by reset
//   timeout_adr  : address of the most recent expired access
module wb_watchdog #(
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          active,
  input  logic          done,
  input  logic [AW-1:0] adr,
  output logic          expire,
  output logic          timeout,
  output logic [AW-1:0] timeout_adr
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // A slave answer on the final cycle wins over the timeout.
  assign expire = active & ~done & (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      timeout     <= 1'b0;
      timeout_adr <= '0;
    end else begin
      if (!active || done || expire) cnt <= '0;
      else                           cnt <= cnt + 1'b1;
      if (expire) begin
        timeout     <= 1'b1;
        timeout_adr <= adr;
      end
    end
  end
endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone B4 classic round-robin arbiter with bus watchdog.
//   wb_clk_i, wb_rst_i        : clock, asynchronous active-high reset
//   m0_*/m1_* inputs          : master request ports (adr/dat/sel/we/cyc/stb)
//   m0_*/m1_* outputs         : read data (broadcast), ack/err (owner only)
//   s_*_o / s_*_i             : single master port toward the interconnect
//   grant_o                   : one-hot current owner, 00 when idle
//   timeout_o, timeout_adr_o  : sticky timeout flag and last timed-out address
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o,
  output logic [AW-1:0]   timeout_adr_o
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t state, state_nxt;
  logic       last_owner;
  logic       req0, req1;
  logic       wd_active, wd_expire;
  logic [AW-1:0] wd_adr;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Read data is broadcast; only the owner sees ack, so the other ignores it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Watchdog sees the raw owner strobe, not the timeout-gated s_stb_o, so
  // there is no combinational loop through the expire gating.
  assign wd_active = ((state == OWN0) & req0) | ((state == OWN1) & req1);
  assign wd_adr    = (state == OWN1) ? m1_adr_i : m0_adr_i;

  wb_watchdog #(
    .AW             (AW),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .active      (wd_active),
    .done        (s_ack_i | s_err_i),
    .adr         (wd_adr),
    .expire      (wd_expire),
    .timeout     (timeout_o),
    .timeout_adr (timeout_adr_o)
  );

  // State register; last_owner updates when the owner releases the bus.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_owner <= OWNER_M1;
    end else begin
      state <= state_nxt;
      if (state == OWN0 && !m0_cyc_i) last_owner <= OWNER_M0;
      if (state == OWN1 && !m1_cyc_i) last_owner <= OWNER_M1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = (last_owner == OWNER_M1) ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
      end
      OWN0:    if (!m0_cyc_i) state_nxt = RELEASE;
      OWN1:    if (!m1_cyc_i) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output muxes. ack/err are qualified by the owner's cyc so a late answer
  // to an aborted access never reaches the master. On expiry cyc/stb are
  // forced low so the slave sees the access terminated.
  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    case (state)
      OWN0: begin
        grant_o  = 2'b01;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i & ~wd_expire;
        s_stb_o  = req0 & ~wd_expire;
        m0_ack_o = m0_cyc_i & s_ack_i;
        m0_err_o = m0_cyc_i & (s_err_i | wd_expire);
      end
      OWN1: begin
        grant_o  = 2'b10;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i & ~wd_expire;
        s_stb_o  = req1 & ~wd_expire;
        m1_ack_o = m1_cyc_i & s_ack_i;
        m1_err_o = m1_cyc_i & (s_err_i | wd_expire);
      end
      default: ;
    endcase
  end
endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Two-master Wishbone B4 classic arbiter placed between the bus requesters and the single master port of wb_intercon.
- m0 is the core load/store path (wishbone_controller). m1 is a boot loader / DMA master that copies SPI-flash contents into IMEM/DMEM.
- Arbitration is round-robin and grant is held for a whole cycle.
- A bus watchdog terminates any slave access that never acks, returning err so the core pipeline cannot stall forever on an unmapped address.

Parameters:
- AW, 32, address width.
- DW, 32, data width (sel width = DW/8).
- TIMEOUT_CYCLES, 255, maximum wait cycles for ack/err once s_stb_o is high; range 2..65535.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), watchdog counter width (derived; not to be overridden).

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous active-high reset
- m0_adr_i / m1_adr_i  in  AW  master address
- m0_dat_i / m1_dat_i  in  DW  master write data
- m0_sel_i / m1_sel_i  in  DW/8  byte selects
- m0_we_i / m1_we_i  in  1  write enable
- m0_cyc_i / m1_cyc_i  in  1  cycle valid
- m0_stb_i / m1_stb_i  in  1  strobe
- m0_dat_o / m1_dat_o  out  DW  read data (s_dat_i broadcast to both)
- m0_ack_o / m1_ack_o  out  1  ack, owner only
- m0_err_o / m1_err_o  out  1  err (slave err or timeout), owner only
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  out  AW/DW/DW/8/1/1/1  to wb_intercon wb_io_*_i
- s_dat_i, s_ack_i, s_err_i  in  DW/1/1  from wb_intercon wb_io_*_o
- grant_o  out  2  one-hot current owner, 00 when idle
- timeout_o  out  1  sticky flag: a watchdog timeout has occurred
- timeout_adr_o  out  AW  address of the most recent timed-out access

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - State = IDLE, grant_o = 00, last_owner = m1 (so m0 wins the first tie), counter = 0, timeout_o = 0, timeout_adr_o = 0.
  - All s_*_o = 0; all m*_ack_o / m*_err_o = 0.
- State machine: IDLE, OWN0, OWN1, RELEASE.
  - IDLE: request means cyc&stb.
    - Only m0 requests -> OWN0. Only m1 requests -> OWN1.
    - Both request -> grant the master that is not last_owner.
    - Transition is registered. The request seen at edge N gives grant_o valid, and s_* driven, in cycle N+1.
  - OWNx:
    - s_adr/dat/sel/we/cyc/stb_o are combinationally muxed from master x.
    - mx_ack_o = s_ack_i and mx_err_o = s_err_i. The other master's ack/err = 0.
    - Grant is held across multiple stb beats while mx_cyc_i stays high.
    - mx_cyc_i low -> RELEASE; last_owner <= x.
  - RELEASE: one dead cycle; all s_* = 0; -> IDLE. Guarantees a cyc gap between owners.
- In IDLE and RELEASE, all s_* outputs = 0 and both masters' ack/err = 0. Waiting masters simply see no ack.
- Owner drops cyc mid-access (abort): s_cyc_o follows combinationally, so the slave sees the abort the same cycle. The next state is RELEASE, and a late s_ack_i is not forwarded.
- Watchdog:
  - Counter clears when s_stb_o = 0 or s_ack_i|s_err_i = 1; otherwise it increments each cycle in OWNx.
  - When counter == TIMEOUT_CYCLES-1 with no ack/err, in that same cycle:
    - owner err_o = 1 and s_stb_o = s_cyc_o = 0 (forced);
    - timeout_o set; timeout_adr_o <= owner address; counter <= 0.
  - State stays OWNx. The master decides whether to retry or drop cyc.
  - If ack arrives on the timeout cycle, ack wins: no err, no flag.
- timeout_o clears only on reset.
- s_err_i is passed through unchanged and does not set timeout_o.
- Reset asserted mid-transfer: all outputs drop immediately (asynchronous); no ack/err is delivered.

Decomposition:
- Package wb_arb_pkg:
  - typedef enum logic [1:0] {IDLE, OWN0, OWN1, RELEASE} arb_state_t;
  - localparam OWNER_M0 = 1'b0, OWNER_M1 = 1'b1.
- Sub-module wb_watchdog (counter, compare, capture of timeout_adr) is natural and reusable by other bus bridges.
- The FSM and output muxes stay in the top.

Test Plan:
- Reset, then m0 read of 0x8000_0004, slave acks after 2 cycles with 0xDEAD_BEEF:
  - grant_o = 01 one cycle after request; m0_dat_o = 0xDEAD_BEEF with m0_ack_o = 1.
  - m1_ack_o stays 0; one RELEASE cycle follows, then grant_o = 00.
- m0 and m1 request on the same edge, both held for 3 back-to-back single accesses:
  - Grants alternate m0, m1, m0, m1, m0, m1.
  - s_cyc_o is low for exactly 1 cycle between owners.
- m1 holds cyc for a 4-beat write burst (stb each beat, addr 0x0..0xC) while m0 requests:
  - m0 is not granted until m1 drops cyc plus the RELEASE cycle.
  - All 4 writes reach s_* with sel = 4'hF.
- TIMEOUT_CYCLES = 8, m0 access to 0xA000_0000, slave never acks:
  - m0_err_o pulses exactly on the 8th stb cycle; s_stb_o is forced 0 that cycle.
  - timeout_o = 1; timeout_adr_o = 0xA000_0000.
- Ack arrives on the exact timeout cycle -> ack to m0, no err, timeout_o stays 0.
- Abort and reset:
  - m0 drops cyc mid-wait -> s_cyc_o drops the same cycle; a late ack is not forwarded.
  - wb_rst_i pulsed mid-access -> all s_* and ack/err go 0 asynchronously.
